// File: rtl/mxv_pkg.sv
// Shared constants, frame bytes and FSM state encoding for the matrix-vector sequencer.
package mxv_pkg;

  localparam int N_MAX = 8;
  localparam int DW    = 8;
  localparam int ACC_W = 16;

  localparam logic [7:0] FRAME_START = 8'hFE;
  localparam logic [7:0] FRAME_END   = 8'hEF;
  localparam logic [7:0] CMD_RESULT  = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    MAC,
    TX_BYTE,
    TX_WAIT,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/mxv_mac_lane.sv
// One row lane: multiplies a matrix element by the vector element and accumulates.
// MXV_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module mxv_mac_lane #(
  parameter int DW    = mxv_pkg::DW,
  parameter int ACC_W = mxv_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] prod_ext;

`ifdef MXV_SIGNED_EN
  // Low 2*DW bits of the product of sign-extended operands equal the signed product.
  assign prod     = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
  assign prod_ext = ACC_W'($signed(prod));
`else
  assign prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign prod_ext = ACC_W'(prod);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/mxv_compute_sequencer.sv
// Streams an NxN matrix from row FIFOs against a vector RAM, then sends the results as a UART frame.
// Optional build macro MXV_SIGNED_EN makes the lane arithmetic two's-complement.
module mxv_compute_sequencer #(
  parameter int N_MAX = mxv_pkg::N_MAX,
  parameter int DW    = mxv_pkg::DW,
  parameter int ACC_W = mxv_pkg::ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            n_size,
  input  logic [N_MAX-1:0]      fifo_empty,
  input  logic [N_MAX*DW-1:0]   fifo_data,
  output logic [N_MAX-1:0]      fifo_pop,
  output logic [2:0]            vec_addr,
  input  logic [DW-1:0]         vec_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  import mxv_pkg::*;

  localparam int IDX_W = $clog2(2*N_MAX+4);

  state_t           state;
  logic [2:0]       col;
  logic [3:0]       n_reg;
  logic [IDX_W-1:0] byte_idx;
  logic             wait_first;

  logic [N_MAX-1:0] lane_mask;
  logic             all_ready;
  logic             mac_fire;
  logic             n_legal;
  logic             acc_clr;
  logic [ACC_W-1:0] acc [N_MAX];

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] data_idx;
  logic [15:0]      row_acc;
  logic [7:0]       frame_byte;

  // Lanes at or above the active order never pop and never accumulate.
  generate
    for (genvar gi = 0; gi < N_MAX; gi++) begin : g_lane
      assign lane_mask[gi] = int'(n_reg) > gi;
      assign fifo_pop[gi]  = mac_fire & lane_mask[gi];

      mxv_mac_lane #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (fifo_pop[gi]),
        .a   (fifo_data[gi*DW +: DW]),
        .b   (vec_data),
        .acc (acc[gi])
      );
    end
  endgenerate

  assign all_ready = ~|(fifo_empty & lane_mask);
  assign mac_fire  = (state == MAC) & all_ready;
  assign n_legal   = (n_size != 4'd0) && (int'(n_size) <= N_MAX);
  assign acc_clr   = (state == IDLE) & start & n_legal;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign error = (state == ERR);

  // Frame layout: start, length, command, hi/lo per row, end.
  assign last_idx = IDX_W'({n_reg, 1'b1}) + IDX_W'(2);
  assign data_idx = byte_idx - IDX_W'(3);

  always_comb begin
    row_acc = '0;
    for (int k = 0; k < N_MAX; k++) begin
      if (int'(data_idx[IDX_W-1:1]) == k) row_acc = 16'(acc[k]);
    end
    if (byte_idx == '0)                 frame_byte = FRAME_START;
    else if (byte_idx == IDX_W'(1))     frame_byte = {3'b000, n_reg, 1'b1};
    else if (byte_idx == IDX_W'(2))     frame_byte = CMD_RESULT;
    else if (byte_idx == last_idx)      frame_byte = FRAME_END;
    else if (data_idx[0])               frame_byte = row_acc[7:0];
    else                                frame_byte = row_acc[15:8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      n_reg      <= '0;
      byte_idx   <= '0;
      wait_first <= 1'b0;
      vec_addr   <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n_legal) begin
              n_reg    <= n_size;
              col      <= '0;
              vec_addr <= '0;
              state    <= ADDR;
            end else begin
              state <= ERR;
            end
          end
        end
        ADDR: state <= MAC;
        MAC: begin
          if (all_ready) begin
            if ({1'b0, col} == n_reg - 4'd1) begin
              byte_idx <= '0;
              state    <= TX_BYTE;
            end else begin
              col      <= col + 3'd1;
              vec_addr <= col + 3'd1;
              state    <= ADDR;
            end
          end
        end
        TX_BYTE: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= frame_byte;
            wait_first <= 1'b1;
            state      <= TX_WAIT;
          end
        end
        // The first cycle is skipped because tx_busy only rises after tx_start is seen.
        TX_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            if (byte_idx == last_idx) begin
              state <= DONE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              state    <= TX_BYTE;
            end
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_compute_sequencer.sv
// Scoreboard bench for mxv_compute_sequencer: FIFO, vector RAM and UART models around the DUT.
module tb_mxv_compute_sequencer;
  localparam int N_MAX = 8;
  localparam int DW    = 8;
  localparam int ACC_W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [3:0]          n_size = '0;
  logic [N_MAX-1:0]    fifo_empty;
  logic [N_MAX*DW-1:0] fifo_data;
  logic [N_MAX-1:0]    fifo_pop;
  logic [2:0]          vec_addr;
  logic [DW-1:0]       vec_data = '0;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_busy;
  logic                busy;
  logic                done;
  logic                error;

  always #5 clk = ~clk;

  mxv_compute_sequencer #(.N_MAX(N_MAX), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_size(n_size),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .vec_addr(vec_addr), .vec_data(vec_data), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .done(done), .error(error)
  );

  logic [7:0]       mat [N_MAX][N_MAX];
  logic [7:0]       vec [N_MAX];
  int               rptr [N_MAX];
  int               cur_n = 0;
  logic [N_MAX-1:0] force_empty = '0;
  logic             rewind = 1'b0;
  int               busy_len = 1;
  int               busy_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] held = '0;
  int tx_cnt = 0, done_cnt = 0, err_cnt = 0, pop_cnt = 0;
  int start_busy_err = 0, hold_err = 0, bad_pop = 0;
  int n_checks = 0, n_fails = 0;

  // Peripheral models: show-ahead row FIFOs, registered vector RAM, UART with fixed busy time.
  always @(posedge clk) begin
    for (int r = 0; r < N_MAX; r++) begin
      if (rewind) rptr[r] <= 0;
      else if (fifo_pop[r] && rptr[r] < N_MAX) rptr[r] <= rptr[r] + 1;
    end
    vec_data <= vec[vec_addr];
    if (!rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = (busy_cnt != 0);

  always_comb begin
    fifo_empty = '1;
    fifo_data  = '0;
    for (int r = 0; r < N_MAX; r++) begin
      fifo_empty[r] = (r >= cur_n) || (rptr[r] >= cur_n) || force_empty[r];
      fifo_data[r*DW +: DW] = (rptr[r] < N_MAX) ? mat[r][rptr[r]] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) begin
        rx_q.push_back(tx_data);
        tx_cnt++;
        if (tx_busy) start_busy_err++;
        held = tx_data;
      end else if (tx_busy && tx_data !== held) begin
        hold_err++;
      end
      for (int r = 0; r < N_MAX; r++) begin
        if (fifo_pop[r]) begin
          pop_cnt++;
          if (r >= cur_n || fifo_empty[r]) bad_pop++;
        end
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] mulx(input logic [7:0] a, input logic [7:0] b);
`ifdef MXV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
`else
    return 16'(int'(a) * int'(b));
`endif
  endfunction

  task automatic push_model(input int n);
    logic [15:0] acc;
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'(2*n + 1));
    exp_q.push_back(8'h05);
    for (int r = 0; r < n; r++) begin
      acc = '0;
      for (int c = 0; c < n; c++) acc = acc + mulx(mat[r][c], vec[c]);
      exp_q.push_back(acc[15:8]);
      exp_q.push_back(acc[7:0]);
    end
    exp_q.push_back(8'hEF);
  endtask

  task automatic fill_random(input int n);
    for (int r = 0; r < N_MAX; r++) begin
      vec[r] = 8'($urandom_range(0, 255));
      for (int c = 0; c < N_MAX; c++) mat[r][c] = 8'($urandom_range(0, 255));
    end
    if (n < 1) vec[0] = 8'h00;
  endtask

  task automatic fill_example();
    fill_random(2);
    mat[0][0] = 8'd1; mat[0][1] = 8'd2;
    mat[1][0] = 8'd3; mat[1][1] = 8'd4;
    vec[0] = 8'd5; vec[1] = 8'd6;
  endtask

  task automatic push_example();
    exp_q.push_back(8'hFE); exp_q.push_back(8'h05); exp_q.push_back(8'h05);
    exp_q.push_back(8'h00); exp_q.push_back(8'h11);
    exp_q.push_back(8'h00); exp_q.push_back(8'h27);
    exp_q.push_back(8'hEF);
  endtask

  task automatic run_frame(input int n, input int stall_len, input int restart_at,
                           input bit use_model, input string name);
    int d0, t0, e0, sb0, h0, bp0, lat, k, n_exp;
    bit got_tx, timed_out;
    logic [7:0] got, want;
    cur_n = n;
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    if (use_model) push_model(n);
    d0 = done_cnt; t0 = tx_cnt; e0 = err_cnt;
    sb0 = start_busy_err; h0 = hold_err; bp0 = bad_pop;
    n_size = 4'(n);
    start = 1'b1;
    if (stall_len > 0) force_empty[1] = 1'b1;
    tick();
    start = 1'b0;
    k = 1; lat = 0; got_tx = 1'b0; timed_out = 1'b0;
    while (done_cnt == d0 && !timed_out) begin
      if (stall_len > 0 && k == stall_len + 2) force_empty = '0;
      if (restart_at > 0 && k == restart_at) begin start = 1'b1; n_size = 4'd0; end
      if (restart_at > 0 && k == restart_at + 1) begin start = 1'b0; n_size = 4'(n); end
      if (!got_tx) begin
        if (tx_start) got_tx = 1'b1;
        else if (busy) lat++;
      end
      tick();
      k++;
      if (k > 20000) timed_out = 1'b1;
    end
    force_empty = '0;
    start = 1'b0;
    n_checks++;
    if (timed_out) begin
      n_fails++;
      $display("FAIL %s done_timeout: no done pulse after %0d cycles, required one", name, k);
    end
    n_checks++;
    if (lat !== 2*n + 1 + stall_len) begin
      n_fails++;
      $display("FAIL %s latency: got %0d busy cycles before first tx_start, required %0d", name, lat, 2*n + 1 + stall_len);
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fails++;
      $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt - d0);
    end
    n_checks++;
    if (err_cnt - e0 !== 0) begin
      n_fails++;
      $display("FAIL %s error_pulses: got %0d, required 0", name, err_cnt - e0);
    end
    n_checks++;
    if (tx_cnt - t0 !== 2*n + 4) begin
      n_fails++;
      $display("FAIL %s tx_start_count: got %0d, required %0d", name, tx_cnt - t0, 2*n + 4);
    end
    n_checks++;
    if (start_busy_err - sb0 !== 0 || hold_err - h0 !== 0) begin
      n_fails++;
      $display("FAIL %s uart_protocol: got %0d starts while busy and %0d data changes, required 0 and 0",
               name, start_busy_err - sb0, hold_err - h0);
    end
    n_checks++;
    if (bad_pop - bp0 !== 0) begin
      n_fails++;
      $display("FAIL %s illegal_pop: got %0d pops of empty or inactive rows, required 0", name, bad_pop - bp0);
    end
    for (int r = 0; r < n; r++) begin
      n_checks++;
      if (rptr[r] !== n) begin
        n_fails++;
        $display("FAIL %s pops_row%0d: got %0d, required %0d", name, r, rptr[r], n);
      end
    end
    n_exp = exp_q.size();
    n_checks++;
    if (rx_q.size() !== n_exp) begin
      n_fails++;
      $display("FAIL %s frame_length: got %0d bytes, required %0d", name, rx_q.size(), n_exp);
    end
    for (int i = 0; i < n_exp; i++) begin
      want = exp_q.pop_front();
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL %s byte%0d: got %02h, required %02h", name, i, got, want);
      end
    end
    rx_q.delete();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s idle_after_done: busy got %b, required 0", name, busy);
    end
    $display("frame %s N=%0d stall=%0d bytes=%0d latency=%0d", name, n, stall_len, n_exp, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, error, tx_start, fifo_pop, vec_addr, tx_data} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b error=%b tx_start=%b pop=%h addr=%0d tx_data=%02h, required all 0",
               busy, done, error, tx_start, fifo_pop, vec_addr, tx_data);
    end
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_example();
    busy_len = 1;
    fill_example();
    push_example();
    run_frame(2, 0, 0, 1'b0, "example");
  endtask

  task automatic test_error();
    int e0, p0, t0, d0, sizes[2];
    sizes[0] = 0;
    sizes[1] = 9;
    foreach (sizes[s]) begin
      cur_n = 0;
      e0 = err_cnt; p0 = pop_cnt; t0 = tx_cnt; d0 = done_cnt;
      n_size = 4'(sizes[s]);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      n_checks++;
      if (err_cnt - e0 !== 1) begin
        n_fails++;
        $display("FAIL error_n%0d pulses: got %0d, required 1", sizes[s], err_cnt - e0);
      end
      n_checks++;
      if (pop_cnt - p0 !== 0 || tx_cnt - t0 !== 0 || done_cnt - d0 !== 0) begin
        n_fails++;
        $display("FAIL error_n%0d side_effects: got pops=%0d tx=%0d done=%0d, required 0 0 0",
                 sizes[s], pop_cnt - p0, tx_cnt - t0, done_cnt - d0);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fails++;
        $display("FAIL error_n%0d idle: busy got %b, required 0", sizes[s], busy);
      end
      $display("illegal size N=%0d error pulses=%0d", sizes[s], err_cnt - e0);
    end
  endtask

  task automatic test_stall();
    busy_len = 1;
    fill_example();
    push_example();
    run_frame(2, 3, 0, 1'b0, "stall");
  endtask

  task automatic test_slow_uart();
    busy_len = 10;
    fill_example();
    push_example();
    run_frame(2, 0, 3, 1'b0, "slow_uart");
    busy_len = 1;
  endtask

  task automatic test_boundary();
    busy_len = 2;
    fill_random(1);
    mat[0][0] = 8'hFE;
    vec[0] = 8'h03;
    exp_q.push_back(8'hFE); exp_q.push_back(8'h03); exp_q.push_back(8'h05);
`ifdef MXV_SIGNED_EN
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFA);
`else
    exp_q.push_back(8'h02); exp_q.push_back(8'hFA);
`endif
    exp_q.push_back(8'hEF);
    run_frame(1, 0, 0, 1'b0, "n1_sign");
    fill_random(8);
    run_frame(8, 0, 0, 1'b1, "n_max");
  endtask

  task automatic test_back_to_back();
    int n;
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 8);
      busy_len = $urandom_range(1, 4);
      fill_random(n);
      run_frame(n, 0, 0, 1'b1, "back_to_back");
    end
    busy_len = 1;
  endtask

  task automatic test_reset_midframe();
    int k, t0;
    busy_len = 10;
    fill_example();
    cur_n = 2;
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    n_size = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (rx_q.size() < 4 && k < 2000) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= 2000) begin
      n_fails++;
      $display("FAIL midreset_wait: got %0d bytes before timeout, required 4", rx_q.size());
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, error, tx_start, fifo_pop, vec_addr, tx_data} !== '0) begin
      n_fails++;
      $display("FAIL midreset_outputs: got busy=%b tx_start=%b pop=%h addr=%0d tx_data=%02h, required all 0",
               busy, tx_start, fifo_pop, vec_addr, tx_data);
    end
    repeat (3) tick();
    rst = 1'b1;
    t0 = tx_cnt;
    repeat (30) tick();
    n_checks++;
    if (tx_cnt - t0 !== 0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_no_resume: got %0d tx_start pulses busy=%b, required 0 and 0", tx_cnt - t0, busy);
    end
    $display("reset mid-frame after %0d bytes", rx_q.size());
    rx_q.delete();
    exp_q.delete();
    busy_len = 1;
    fill_example();
    push_example();
    run_frame(2, 0, 0, 1'b0, "after_reset");
  endtask

  initial begin
    for (int r = 0; r < N_MAX; r++) begin
      rptr[r] = 0;
      vec[r] = 8'h00;
      for (int c = 0; c < N_MAX; c++) mat[r][c] = 8'h00;
    end
    test_reset();
    test_example();
    test_error();
    test_stall();
    test_slow_uart();
    test_boundary();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
